mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have no parameters; opcode values and state encodings are fixed by this document.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 6 bits: instruction[31:26] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1 bit: the memory access completes in this cycle.
REQ-006 SHALL have ports pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, output, 1 bit each: datapath enables and mux selects.
REQ-007 SHALL have ports alu_src_b and pc_source, output, 2 bits each: mux selects.
REQ-008 SHALL have port alu_op, output, 3 bits: code driven into the ALU control decoder (000 add, 001 subtract, 011 funct-decoded R-type).
REQ-009 SHALL have port state, output, 4 bits: current state for debug.
REQ-010 SHALL have port illegal_op, output, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-011 SHALL be a Moore FSM with the following state encoding:
- FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
- EXEC=6, R_WB=7, BRANCH=8, ADDI_EX=9, ADDI_WB=10, JUMP=11
- Codes 12-15 are unused and SHALL go to FETCH on the next edge.
REQ-012 SHALL decode only these opcodes: R-type 6'h00, lw 6'h23, sw 6'h2B, beq 6'h04, addi 6'h08, j 6'h02.
REQ-013 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000 and pc_source=00.
REQ-014 FETCH SHALL assert ir_write=1 and pc_write=1 only in a cycle where mem_ready=1.
REQ-015 FETCH SHALL hold (state unchanged, no ir_write/pc_write) while mem_ready=0, and go to DECODE when mem_ready=1.
REQ-016 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=000 (branch-target precompute).
REQ-017 DECODE SHALL transition by opcode:
- lw or sw -> MEM_ADDR
- R-type -> EXEC
- beq -> BRANCH
- addi -> ADDI_EX
- j -> JUMP
- any other opcode -> FETCH, with illegal_op=1 in this DECODE cycle only.
REQ-018 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=000, then go to MEM_RD for lw or MEM_WR for sw.
REQ-019 MEM_RD SHALL drive mem_read=1 and iord=1, holding until mem_ready=1, then go to MEM_WB.
REQ-020 MEM_WB SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-021 MEM_WR SHALL drive mem_write=1 and iord=1, holding until mem_ready=1, then go to FETCH.
- mem_write SHALL stay asserted on every cycle of the hold.
REQ-022 EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=011, then go to R_WB.
REQ-023 R_WB SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-024 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1 and pc_source=01, then go to FETCH.
REQ-025 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=000, then go to ADDI_WB.
REQ-026 ADDI_WB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-027 JUMP SHALL drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-028 Any output not listed for a state SHALL be 0 in that state.
REQ-029 SHALL sample opcode only in DECODE and MEM_ADDR; opcode changes in other states SHALL have no effect.
REQ-030 Instruction latency with mem_ready continuously 1 SHALL be (FETCH-to-FETCH cycles):
- lw 5
- sw, R-type, addi 4
- beq, j 3
- each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR SHALL add one cycle.

Reset
REQ-031 While reset_n=0, regardless of clk, SHALL force state=FETCH and all outputs to 0, including FETCH's mem_read.
REQ-032 On the first rising edge after reset_n rises, SHALL present FETCH outputs; a reset asserted mid-instruction (including MEM_WR) SHALL drop mem_write and reg_write immediately.

Verification
REQ-033 R-type, opcode=00, mem_ready=1 -> states 0,1,6,7,0; alu_op=011 in state 6; reg_write=1 and reg_dst=1 in state 7 only.
REQ-034 lw, opcode=23, mem_ready low for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0; mem_to_reg=1 and reg_write=1 only in state 4.
REQ-035 FETCH with mem_ready=0 for 3 cycles -> state stays 0; ir_write=0 and pc_write=0 until the mem_ready=1 cycle, then both are 1 for exactly one cycle.
REQ-036 opcode=3F in DECODE -> illegal_op=1 for one cycle; next state 0; no reg_write, mem_write or pc_write asserted.
REQ-037 beq, opcode=04 -> states 0,1,8,0; pc_write_cond=1, alu_op=001 and pc_source=01 in state 8.
REQ-038 sw with reset_n pulled low during MEM_WR -> mem_write drops to 0 asynchronously; state=0; after release the FSM resumes from FETCH.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle MIPS-style datapath controller: Moore FSM with mem_ready handshakes.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles FETCH-to-FETCH. Each mem_ready=0 cycle adds one.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their state and outputs until mem_ready=1.
module mc_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDI_EX  = 4'd9;
    localparam logic [3:0] S_ADDI_WB  = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    logic [3:0] state_q, state_d;
    // run_q is cleared by reset and set on the first edge after release, so
    // every output (including FETCH's mem_read) stays low while reset is held.
    logic       run_q, run_d;

    assign run_d = 1'b1;
    assign state = state_q;

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Next-state logic; opcode only matters in DECODE and MEM_ADDR
    always_comb begin
        state_d = state_q;
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDI_EX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
                S_MEM_WB:   state_d = S_FETCH;
                S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
                S_EXEC:     state_d = S_R_WB;
                S_R_WB:     state_d = S_FETCH;
                S_BRANCH:   state_d = S_FETCH;
                S_ADDI_EX:  state_d = S_ADDI_WB;
                S_ADDI_WB:  state_d = S_FETCH;
                S_JUMP:     state_d = S_FETCH;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    // Moore output decode; everything defaults low and is gated by run_q
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 3'b000;
        illegal_op    = 1'b0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                        default:                                      illegal_op = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'b011;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 3'b001;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-cycle expected observations go into a scoreboard
// queue as stimulus is driven; a negedge monitor pops and compares them.
// Reset-specific behaviour is checked inline in the scenario tasks.
module tb_mc_control;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op;
    } obs_t;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       illegal_op;

    obs_t  act;
    obs_t  sb_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    mc_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .state(state), .illegal_op(illegal_op)
    );

    assign act = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                  alu_op, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a state, written from the per-state output table
    function automatic obs_t exp_out(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        obs_t e;
        e = '0;
        e.state = st;
        case (st)
            4'd0: begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            4'd1: begin
                e.alu_src_b = 2'b11;
                e.illegal_op = !(op == 6'h00 || op == 6'h23 || op == 6'h2B ||
                                 op == 6'h04 || op == 6'h08 || op == 6'h02);
            end
            4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd3:  begin e.mem_read = 1; e.iord = 1; end
            4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            4'd5:  begin e.mem_write = 1; e.iord = 1; end
            4'd6:  begin e.alu_src_a = 1; e.alu_op = 3'b011; end
            4'd7:  begin e.reg_write = 1; e.reg_dst = 1; end
            4'd8:  begin e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_write_cond = 1; e.pc_source = 2'b01; end
            4'd9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd10: begin e.reg_write = 1; end
            4'd11: begin e.pc_write = 1; e.pc_source = 2'b10; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Scoreboard monitor: compare the oldest expectation mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            obs_t  e;
            string n;
            e = sb_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                         n, act, e, act.state, e.state);
            end
        end
    end

    // One clock cycle of stimulus with its expected observation
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [3:0] st, input string nm);
        opcode    = op;
        mem_ready = rdy;
        sb_q.push_back(exp_out(st, rdy, op));
        nm_q.push_back(nm);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_read !== 1'b0 || state !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: mem_read=%b state=%0d required 0/0", mem_read, state);
        end
        repeat (2) begin
            sb_q.push_back('0);
            nm_q.push_back("reset_outputs");
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        sb_q.push_back('0);
        nm_q.push_back("release_before_edge");
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_rtype();
        cyc(6'h00, 1, 4'd0, "rt_fetch");
        cyc(6'h00, 1, 4'd1, "rt_decode");
        cyc(6'h23, 1, 4'd6, "rt_exec_opcode_ignored");
        cyc(6'h2B, 1, 4'd7, "rt_wb");
    endtask

    task automatic test_lw_stall();
        cyc(6'h23, 1, 4'd0, "lw_fetch");
        cyc(6'h23, 1, 4'd1, "lw_decode");
        cyc(6'h23, 1, 4'd2, "lw_addr");
        cyc(6'h23, 0, 4'd3, "lw_rd_wait1");
        cyc(6'h23, 0, 4'd3, "lw_rd_wait2");
        cyc(6'h23, 1, 4'd3, "lw_rd_done");
        cyc(6'h00, 1, 4'd4, "lw_wb");
    endtask

    task automatic test_fetch_stall();
        cyc(6'h00, 0, 4'd0, "fetch_wait1");
        cyc(6'h00, 0, 4'd0, "fetch_wait2");
        cyc(6'h00, 0, 4'd0, "fetch_wait3");
        cyc(6'h00, 1, 4'd0, "fetch_ready");
        cyc(6'h00, 1, 4'd1, "fetch_stall_decode");
        cyc(6'h00, 1, 4'd6, "fetch_stall_exec");
        cyc(6'h00, 1, 4'd7, "fetch_stall_wb");
    endtask

    task automatic test_illegal();
        cyc(6'h3F, 1, 4'd0, "ill_fetch");
        cyc(6'h3F, 1, 4'd1, "ill_decode");
        checks++;
        if (state !== 4'd0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL ill_after: state=%0d illegal_op=%b required 0/0", state, illegal_op);
        end
    endtask

    task automatic test_beq_addi();
        cyc(6'h04, 1, 4'd0, "beq_fetch");
        cyc(6'h04, 1, 4'd1, "beq_decode");
        cyc(6'h04, 1, 4'd8, "beq_branch");
        cyc(6'h08, 1, 4'd0, "addi_fetch");
        cyc(6'h08, 1, 4'd1, "addi_decode");
        cyc(6'h08, 1, 4'd9, "addi_ex");
        cyc(6'h08, 1, 4'd10, "addi_wb");
    endtask

    task automatic test_sw_stall();
        cyc(6'h2B, 1, 4'd0, "sw_fetch");
        cyc(6'h2B, 1, 4'd1, "sw_decode");
        cyc(6'h2B, 1, 4'd2, "sw_addr");
        cyc(6'h23, 0, 4'd5, "sw_wr_wait1");
        cyc(6'h23, 0, 4'd5, "sw_wr_wait2");
        cyc(6'h23, 1, 4'd5, "sw_wr_done");
    endtask

    task automatic test_back_to_back();
        cyc(6'h02, 1, 4'd0, "b2b_j_fetch");
        cyc(6'h02, 1, 4'd1, "b2b_j_decode");
        cyc(6'h02, 1, 4'd11, "b2b_j_jump");
        cyc(6'h04, 1, 4'd0, "b2b_beq_fetch");
        cyc(6'h04, 1, 4'd1, "b2b_beq_decode");
        cyc(6'h04, 1, 4'd8, "b2b_beq_branch");
    endtask

    task automatic test_sw_reset();
        cyc(6'h2B, 1, 4'd0, "swr_fetch");
        cyc(6'h2B, 1, 4'd1, "swr_decode");
        cyc(6'h2B, 1, 4'd2, "swr_addr");
        cyc(6'h2B, 0, 4'd5, "swr_wr_hold");
        mem_ready = 1'b0;
        checks++;
        if (mem_write !== 1'b1 || state !== 4'd5) begin
            errors++;
            $display("FAIL swr_still_writing: mem_write=%b state=%0d required 1/5", mem_write, state);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || state !== 4'd0 || reg_write !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL swr_async_drop: mem_write=%b state=%0d reg_write=%b mem_read=%b required 0/0/0/0",
                     mem_write, state, reg_write, mem_read);
        end
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(6'h02, 1, 4'd0, "swr_resume_fetch");
        cyc(6'h02, 1, 4'd1, "swr_resume_decode");
        cyc(6'h02, 1, 4'd11, "swr_resume_jump");
        cyc(6'h00, 0, 4'd0, "swr_resume_back");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_fetch_stall();
        test_illegal();
        test_beq_addi();
        test_sw_stall();
        test_back_to_back();
        test_sw_reset();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
